regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised integer register file with a per-register pending (scoreboard) bit.
//   Successor to the single-cycle processor's 32x64 register file, for the pipelined core.
//   Adds: async clear, hardwired-zero x0, hazard detection and issue stall.
//   Sits between decode (read/issue) and writeback.
// PARAMETERS
//   XLEN   64  data width of each register
//   AW     5   register address width
//   NREGS  32  register count; must equal 1<<AW
// PORTS
//   clk          in   1      single clock; all state updates on posedge
//   reset        in   1      asynchronous, active-high; clears all state immediately
//   rs1          in   AW     read-port-1 address (combinational read)
//   rs2          in   AW     read-port-2 address (combinational read)
//   issue_valid  in   1      decode requests to issue an instruction
//   issue_rd     in   AW     destination of the issuing instruction; becomes pending
//   wb_valid     in   1      writeback strobe
//   wb_rd        in   AW     writeback destination
//   wb_data      in   XLEN   writeback data
//   read_data1   out  XLEN   value of rs1
//   read_data2   out  XLEN   value of rs2
//   rs1_busy     out  1      rs1 has an outstanding producer
//   rs2_busy     out  1      rs2 has an outstanding producer
//   stall        out  1      issue blocked this cycle
//   pending      out  NREGS  scoreboard vector; bit i = register i awaiting writeback
// BEHAVIOUR
//   Reset (async, any time, including mid-operation):
//   - all NREGS registers and all pending bits = 0 immediately.
//   - read_data1/2 = 0; busy, stall and pending = 0 while reset is high.
//   Register 0:
//   - always reads 0 and is never pending.
//   - writes to and issues against register 0 are silently dropped.
//   Write: at posedge, if wb_valid && wb_rd!=0: reg[wb_rd] <= wb_data.
//   - A write to a non-pending register is legal and updates data.
//   Read: combinational, zero latency.
//   - read_dataN = reg[rsN], or 0 if rsN==0; bypass rules are under CONFIGURATION.
//   Busy: rsN_busy = pending[rsN], except when cleared by bypass.
//   Stall: stall = issue_valid && (rs1_busy || rs2_busy || (issue_rd!=0 && pending[issue_rd])).
//   - The last term is the WAW check.
//   - The sources are not qualified by the opcode; decode masks unused rs fields to 0.
//   Scoreboard update at posedge:
//   - Set:   issue_valid && !stall && issue_rd!=0  -> pending[issue_rd] <= 1.
//   - Clear: wb_valid && wb_rd!=0                  -> pending[wb_rd] <= 0.
//   - Set and clear on the same register in the same cycle: set wins (new producer outstanding).
//   - Set and clear on different registers proceed independently.
//   Latency:
//   - A write is visible on the read ports the cycle after its posedge (0 cycles with bypass).
//   - A pending bit is visible the cycle after issue.
// CONFIGURATION
//   Macro REGFILE_BYPASS_EN.
//   Defined:
//   - if wb_valid && wb_rd==rsN && rsN!=0: read_dataN = wb_data and rsN_busy = 0 in the same cycle.
//   - A consumer issues in the same cycle as its producer's writeback.
//   Undefined:
//   - no forwarding; read_dataN always comes from the array and rsN_busy = pending[rsN].
//   - A consumer stalls one extra cycle, issuing the cycle after the writeback.
// TESTING
//   1. Reset: load x5=0xAA via wb, pulse reset asynchronously between edges -> read_data1=0 immediately; pending=0.
//   2. x0: wb_valid wb_rd=0 wb_data=0xFFFF; rs1=0 -> read_data1=0; issue_rd=0 -> pending[0] stays 0, no stall.
//   3. RAW stall: issue_rd=3 (cycle 0); cycle 1 rs1=3 issue_valid -> stall=1, rs1_busy=1.
//      Cycle 2 wb_rd=3 wb_data=0x1234:
//      - BYPASS_EN: stall=0 and read_data1=0x1234 in cycle 2.
//      - Otherwise: stall=1 in cycle 2; stall=0 and read_data1=0x1234 in cycle 3.
//   4. WAW: x7 pending, issue_rd=7 -> stall=1 until wb_rd=7; pending[7] stays 0 while stalled.
//   5. Simultaneous events on the same register:
//      - wb_rd=9 with x9 pending, and issue_rd=9 (rs1=rs2=0) in the same cycle.
//      - BYPASS_EN: no stall, pending[9]=1 afterwards (set wins); x9 data updated.
//      - Otherwise: stall=1 (WAW); pending[9]=0 next cycle; issue proceeds the following cycle.
//   6. Dual port: x1=11, x2=22 written; rs1=1, rs2=2 -> read_data1=11, read_data2=22.
//      Different-register set (issue_rd=4) and clear (wb_rd=1) in one cycle -> pending[4]=1, pending[1]=0.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bundle for the scoreboarded register file.
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int NREGS = 32
);
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [XLEN-1:0]  read_data1;
  logic [XLEN-1:0]  read_data2;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             stall;
  logic [NREGS-1:0] pending;

  modport master (
    output rs1, rs2, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
    input  read_data1, read_data2, rs1_busy, rs2_busy, stall, pending
  );

  modport slave (
    input  rs1, rs2, issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
    output read_data1, read_data2, rs1_busy, rs2_busy, stall, pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending bits, hazard detection and issue stall.
// Optional writeback-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int AW    = 5,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  logic             wb_we;
  logic             issue_fire;
  logic [XLEN-1:0]  rd1;
  logic [XLEN-1:0]  rd2;
  logic             busy1;
  logic             busy2;
  logic             waw;
  logic             stall_raw;

  assign wb_we = bus.wb_valid && (bus.wb_rd != '0);

  // Read ports, busy flags and WAW check; forwarding also hides the pending bit it resolves.
  always_comb begin
    rd1   = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
    rd2   = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
    busy1 = pending_q[bus.rs1];
    busy2 = pending_q[bus.rs2];
    waw   = (bus.issue_rd != '0) && pending_q[bus.issue_rd];
`ifdef REGFILE_BYPASS_EN
    if (wb_we && (bus.wb_rd == bus.rs1)) begin
      rd1   = bus.wb_data;
      busy1 = 1'b0;
    end
    if (wb_we && (bus.wb_rd == bus.rs2)) begin
      rd2   = bus.wb_data;
      busy2 = 1'b0;
    end
    if (wb_we && (bus.wb_rd == bus.issue_rd)) begin
      waw = 1'b0;
    end
`endif
  end

  assign stall_raw  = bus.issue_valid && (busy1 || busy2 || waw);
  assign issue_fire = bus.issue_valid && !stall_raw && (bus.issue_rd != '0);

  // Clear is applied before set so a new producer on the same register stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (wb_we) begin
      pending_d[bus.wb_rd] = 1'b0;
    end
    if (issue_fire) begin
      pending_d[bus.issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      if (wb_we) begin
        regs_q[bus.wb_rd] <= bus.wb_data;
      end
      pending_q <= pending_d;
    end
  end

  assign bus.read_data1 = reset ? '0 : rd1;
  assign bus.read_data2 = reset ? '0 : rd2;
  assign bus.rs1_busy   = !reset && busy1;
  assign bus.rs2_busy   = !reset && busy2;
  assign bus.stall      = !reset && stall_raw;
  assign bus.pending    = reset ? '0 : pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;

  localparam int XLEN  = 64;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  regfile_scoreboard_if #(.XLEN(XLEN), .AW(AW), .NREGS(NREGS)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic issueValid, input logic [AW-1:0] issueRd,
                               input logic wbValid, input logic [AW-1:0] wbRd,
                               input logic [XLEN-1:0] wbData,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bus.issue_valid = issueValid;
    bus.issue_rd    = issueRd;
    bus.wb_valid    = wbValid;
    bus.wb_rd       = wbRd;
    bus.wb_data     = wbData;
    bus.rs1         = rs1;
    bus.rs2         = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #2;
    nCompared++;
    if (bus.read_data1 !== 64'h0 || bus.pending !== 32'h0 || bus.stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_init: rd1=%h pending=%h stall=%b expected 0/0/0",
               bus.read_data1, bus.pending, bus.stall);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 5'd6, 1'b1, 5'd5, 64'hAA, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
    #1;
    nCompared++;
    if (bus.read_data1 !== 64'hAA || bus.pending !== 32'h0000_0040) begin
      nMismatched++;
      $display("[TB] FAIL reset_preload: rd1=%h pending=%h expected aa/00000040",
               bus.read_data1, bus.pending);
    end
    #2;
    reset = 1'b1;
    #1;
    nCompared++;
    if (bus.read_data1 !== 64'h0 || bus.pending !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_async: rd1=%h pending=%h expected 0/0", bus.read_data1, bus.pending);
    end
    #1;
    reset = 1'b0;
    tick();
    nCompared++;
    if (bus.read_data1 !== 64'h0 || bus.pending !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_cleared: rd1=%h pending=%h expected 0/0", bus.read_data1, bus.pending);
    end
  endtask

  task automatic test_x0();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 64'hFFFF, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.read_data1 !== 64'h0 || bus.stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL x0_same_cycle: rd1=%h stall=%b expected 0/0", bus.read_data1, bus.stall);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.read_data1 !== 64'h0 || bus.pending !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL x0_after: rd1=%h pending=%h expected 0/0", bus.read_data1, bus.pending);
    end
  endtask

  task automatic test_raw_stall();
    applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL raw_c0_stall: stall=%b expected 0", bus.stall);
    end
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b1 || bus.rs1_busy !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL raw_c1: stall=%b rs1_busy=%b expected 1/1", bus.stall, bus.rs1_busy);
    end
    tick();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd3, 64'h1234, 5'd3, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    nCompared++;
    if (bus.stall !== 1'b0 || bus.read_data1 !== 64'h1234) begin
      nMismatched++;
      $display("[TB] FAIL raw_c2_bypass: stall=%b rd1=%h expected 0/1234", bus.stall, bus.read_data1);
    end
`else
    nCompared++;
    if (bus.stall !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL raw_c2: stall=%b expected 1", bus.stall);
    end
`endif
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b0 || bus.read_data1 !== 64'h1234 || bus.pending !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL raw_c3: stall=%b rd1=%h pending=%h expected 0/1234/0",
               bus.stall, bus.read_data1, bus.pending);
    end
    tick();
  endtask

  task automatic test_waw();
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL waw_stall: stall=%b expected 1", bus.stall);
    end
    tick();
    #1;
    nCompared++;
    if (bus.stall !== 1'b1 || bus.pending !== 32'h0000_0080) begin
      nMismatched++;
      $display("[TB] FAIL waw_hold: stall=%b pending=%h expected 1/00000080", bus.stall, bus.pending);
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 64'h77, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b0 || bus.pending !== 32'h0) begin
      nMismatched++;
      $display("[TB] FAIL waw_release: stall=%b pending=%h expected 0/0", bus.stall, bus.pending);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 64'h77, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.pending !== 32'h0000_0080) begin
      nMismatched++;
      $display("[TB] FAIL waw_reissued: pending=%h expected 00000080", bus.pending);
    end
    tick();
  endtask

  task automatic test_same_reg();
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 64'h99, 5'd0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    nCompared++;
    if (bus.stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL same_reg_stall: stall=%b expected 0", bus.stall);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd0);
    #1;
    nCompared++;
    if (bus.pending !== 32'h0000_0200 || bus.read_data1 !== 64'h99) begin
      nMismatched++;
      $display("[TB] FAIL same_reg_setwins: pending=%h rd1=%h expected 00000200/99",
               bus.pending, bus.read_data1);
    end
`else
    nCompared++;
    if (bus.stall !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL same_reg_stall: stall=%b expected 1", bus.stall);
    end
    tick();
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.pending !== 32'h0 || bus.stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL same_reg_cleared: pending=%h stall=%b expected 0/0", bus.pending, bus.stall);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd9, 5'd0);
    #1;
    nCompared++;
    if (bus.pending !== 32'h0000_0200 || bus.read_data1 !== 64'h99) begin
      nMismatched++;
      $display("[TB] FAIL same_reg_reissue: pending=%h rd1=%h expected 00000200/99",
               bus.pending, bus.read_data1);
    end
`endif
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd9, 64'h99, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_dual_port();
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd1, 64'd11, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 64'd22, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd1, 5'd2);
    #1;
    nCompared++;
    if (bus.read_data1 !== 64'd11 || bus.read_data2 !== 64'd22) begin
      nMismatched++;
      $display("[TB] FAIL dual_read: rd1=%0d rd2=%0d expected 11/22", bus.read_data1, bus.read_data2);
    end
    nCompared++;
    if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0 || bus.pending !== 32'h0000_0002) begin
      nMismatched++;
      $display("[TB] FAIL dual_busy: rs1_busy=%b rs2_busy=%b pending=%h expected 1/0/00000002",
               bus.rs1_busy, bus.rs2_busy, bus.pending);
    end
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd1, 64'd11, 5'd0, 5'd0);
    #1;
    nCompared++;
    if (bus.stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL dual_setclr_stall: stall=%b expected 0", bus.stall);
    end
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd1, 5'd4);
    #1;
    nCompared++;
    if (bus.pending !== 32'h0000_0010 || bus.rs2_busy !== 1'b1 || bus.rs1_busy !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL dual_setclr: pending=%h rs1_busy=%b rs2_busy=%b expected 00000010/0/1",
               bus.pending, bus.rs1_busy, bus.rs2_busy);
    end
    applyStimulus(1'b0, 5'd0, 1'b1, 5'd4, 64'h44, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 5'd4, 5'd2);
    #1;
    nCompared++;
    if (bus.pending !== 32'h0 || bus.read_data1 !== 64'h44 || bus.read_data2 !== 64'd22) begin
      nMismatched++;
      $display("[TB] FAIL dual_final: pending=%h rd1=%h rd2=%0d expected 0/44/22",
               bus.pending, bus.read_data1, bus.read_data2);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_x0();
    test_raw_stall();
    test_waw();
    test_same_reg();
    test_dual_port();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
